// File: rtl/counter_bcd_n.sv
// Multi-digit BCD up/down counter with wrap, saturate, stop and auto-reload
// terminal behaviour, synchronous clear/load with load validation.
module counter_bcd_n #(
   parameter int DIGITS  = 2,
   parameter int MAX_VAL = 99,
   parameter int PRESET  = 25
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic [1:0]            mode,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic                  ovf,
   output logic                  done,
   output logic                  err
);

   localparam int W = 4 * DIGITS;

   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_SAT    = 2'b01;
   localparam logic [1:0] MODE_STOP   = 2'b10;
   localparam logic [1:0] MODE_RELOAD = 2'b11;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD    = to_bcd(MAX_VAL);
   localparam logic [W-1:0] PRESET_BCD = to_bcd(PRESET);

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic           digits_ok;
   logic           load_ok;
   logic [W-1:0]   step_val;
   logic [W-1:0]   term_val;

   // With all digits valid, an unsigned compare of BCD words is a decimal compare.
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
      end
   end

   assign load_ok  = digits_ok && (load_val <= MAX_BCD);
   assign step_val = up ? bcd_inc(count) : bcd_dec(count);
   assign term_val = up ? MAX_BCD : '0;
   assign tc       = (count == term_val);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
         ovf   <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         ovf <= 1'b0;
         err <= 1'b0;
         if (clr) begin
            count <= '0;
            done  <= 1'b0;
         end else if (load) begin
            if (load_ok) begin
               count <= load_val;
               done  <= 1'b0;
            end else begin
               err <= 1'b1;
            end
         end else if (en && !done) begin
            if (tc) begin
               case (mode)
                  MODE_WRAP: begin
                     count <= up ? '0 : MAX_BCD;
                     ovf   <= 1'b1;
                  end
                  MODE_SAT:    count <= count;
                  MODE_STOP:   done  <= 1'b1;
                  MODE_RELOAD: begin
                     count <= PRESET_BCD;
                     ovf   <= 1'b1;
                  end
                  default:     count <= count;
               endcase
            end else begin
               count <= step_val;
               if (mode == MODE_STOP && step_val == term_val) done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_bcd_n.sv
// Directed bench for counter_bcd_n: a 00..99 instance and a 00..59 instance
// driven from the same stimulus.
module tb_counter_bcd_n;

   logic       clock;
   logic       reset;
   logic       en;
   logic       up;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [1:0] mode;
   logic [7:0] count;
   logic       tc;
   logic       ovf;
   logic       done;
   logic       err;
   logic [7:0] count59;
   logic       tc59;
   logic       ovf59;
   logic       done59;
   logic       err59;

   int n_checks = 0;
   int n_fail   = 0;

   counter_bcd_n #(.DIGITS(2), .MAX_VAL(99), .PRESET(25)) dut (
      .clock(clock), .reset(reset), .en(en), .up(up), .clr(clr),
      .load(load), .load_val(load_val), .mode(mode),
      .count(count), .tc(tc), .ovf(ovf), .done(done), .err(err)
   );

   counter_bcd_n #(.DIGITS(2), .MAX_VAL(59), .PRESET(25)) dut59 (
      .clock(clock), .reset(reset), .en(en), .up(up), .clr(clr),
      .load(load), .load_val(load_val), .mode(mode),
      .count(count59), .tc(tc59), .ovf(ovf59), .done(done59), .err(err59)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] bcd(input int v);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'((v / 10) % 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      en = 1'b0; clr = 1'b0; load = 1'b0;
   endtask

   task automatic do_clr();
      idle(); clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v);
      idle(); load = 1'b1; load_val = v; tick(); load = 1'b0;
   endtask

   task automatic do_step(input logic dir);
      idle(); up = dir; en = 1'b1; tick(); en = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", count); end
      n_checks++; if ({ovf, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {ovf, done, err}); end
      up = 1'b1; #1;
      n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up got=%b exp=0", tc); end
      up = 1'b0; #1;
      n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down got=%b exp=1", tc); end
      @(negedge clock);
      reset = 1'b1;
      up = 1'b1;
   endtask

   task automatic test_wrap_up();
      int n_ovf;
      n_ovf = 0;
      mode = 2'b00;
      do_clr();
      for (int i = 1; i <= 100; i++) begin
         do_step(1'b1);
         if (ovf === 1'b1) n_ovf++;
         n_checks++; if (count !== bcd(i % 100)) begin n_fail++; $display("FAIL wrap_up_count step=%0d got=%h exp=%h", i, count, bcd(i % 100)); end
         n_checks++; if (ovf !== (i == 100)) begin n_fail++; $display("FAIL wrap_up_ovf step=%0d got=%b exp=%b", i, ovf, (i == 100)); end
         if (i == 99) begin
            n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_up_tc99 got=%b exp=1", tc); end
         end
      end
      n_checks++; if (n_ovf !== 1) begin n_fail++; $display("FAIL wrap_up_ovf_total got=%0d exp=1", n_ovf); end
   endtask

   task automatic test_wrap_down();
      mode = 2'b00;
      do_load(8'h10);
      do_step(1'b0);
      n_checks++; if (count !== 8'h09) begin n_fail++; $display("FAIL down_borrow got=%h exp=09", count); end
      do_load(8'h01);
      do_step(1'b0);
      n_checks++; if (count !== 8'h00 || ovf !== 1'b0) begin n_fail++; $display("FAIL down_to_zero got=%h/%b exp=00/0", count, ovf); end
      do_step(1'b0);
      n_checks++; if (count !== 8'h99 || ovf !== 1'b1) begin n_fail++; $display("FAIL down_wrap got=%h/%b exp=99/1", count, ovf); end
      tick();
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL down_ovf_pulse got=%b exp=0", ovf); end
   endtask

   task automatic test_saturate();
      mode = 2'b01;
      do_load(8'h99);
      do_step(1'b1);
      n_checks++; if (count !== 8'h99 || ovf !== 1'b0) begin n_fail++; $display("FAIL sat_up got=%h/%b exp=99/0", count, ovf); end
      do_load(8'h00);
      do_step(1'b0);
      n_checks++; if (count !== 8'h00 || ovf !== 1'b0) begin n_fail++; $display("FAIL sat_down got=%h/%b exp=00/0", count, ovf); end
   endtask

   task automatic test_stop();
      mode = 2'b10;
      do_load(8'h97);
      do_step(1'b1);
      n_checks++; if (count !== 8'h98 || done !== 1'b0) begin n_fail++; $display("FAIL stop_98 got=%h/%b exp=98/0", count, done); end
      do_step(1'b1);
      n_checks++; if (count !== 8'h99 || done !== 1'b1) begin n_fail++; $display("FAIL stop_99 got=%h/%b exp=99/1", count, done); end
      do_step(1'b0);
      n_checks++; if (count !== 8'h99 || done !== 1'b1) begin n_fail++; $display("FAIL stop_hold got=%h/%b exp=99/1", count, done); end
      do_clr();
      n_checks++; if (count !== 8'h00 || done !== 1'b0) begin n_fail++; $display("FAIL stop_clr got=%h/%b exp=00/0", count, done); end
   endtask

   task automatic test_reload();
      mode = 2'b11;
      do_load(8'h99);
      do_step(1'b1);
      n_checks++; if (count !== 8'h25 || ovf !== 1'b1) begin n_fail++; $display("FAIL reload_up got=%h/%b exp=25/1", count, ovf); end
      up = 1'b0;
      do_load(8'h00);
      n_checks++; if (tc !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL reload_tc0 got=%b/%b exp=1/0", tc, ovf); end
      do_step(1'b0);
      n_checks++; if (count !== 8'h25 || ovf !== 1'b1) begin n_fail++; $display("FAIL reload_down got=%h/%b exp=25/1", count, ovf); end
   endtask

   task automatic test_load();
      do_load(8'h3A);
      n_checks++; if (count !== 8'h25 || err !== 1'b1) begin n_fail++; $display("FAIL load_bad got=%h/%b exp=25/1", count, err); end
      tick();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL load_err_pulse got=%b exp=0", err); end
      do_load(8'h42);
      n_checks++; if (count !== 8'h42 || err !== 1'b0) begin n_fail++; $display("FAIL load_good got=%h/%b exp=42/0", count, err); end
      idle(); clr = 1'b1; load = 1'b1; load_val = 8'h42; tick(); idle();
      n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL clr_over_load got=%h exp=00", count); end
   endtask

   task automatic test_back_to_back();
      mode = 2'b00;
      do_load(8'h50);
      idle(); en = 1'b1;
      up = 1'b1; tick();
      n_checks++; if (count !== 8'h51) begin n_fail++; $display("FAIL b2b_up got=%h exp=51", count); end
      up = 1'b0; tick();
      n_checks++; if (count !== 8'h50) begin n_fail++; $display("FAIL b2b_down1 got=%h exp=50", count); end
      tick();
      n_checks++; if (count !== 8'h49) begin n_fail++; $display("FAIL b2b_down2 got=%h exp=49", count); end
      idle();
   endtask

   task automatic test_async_reset();
      mode = 2'b00;
      do_load(8'h56);
      idle(); up = 1'b1; en = 1'b1; tick();
      n_checks++; if (count !== 8'h57) begin n_fail++; $display("FAIL areset_pre got=%h exp=57", count); end
      #3 reset = 1'b0;
      #1;
      n_checks++; if (count !== 8'h00 || {ovf, done, err} !== 3'b000) begin n_fail++; $display("FAIL areset_now got=%h/%b exp=00/000", count, {ovf, done, err}); end
      #2 reset = 1'b1;
      tick();
      n_checks++; if (count !== 8'h01) begin n_fail++; $display("FAIL areset_resume got=%h exp=01", count); end
      idle();
   endtask

   task automatic test_max59();
      mode = 2'b00;
      do_clr();
      for (int i = 1; i <= 59; i++) begin
         do_step(1'b1);
         n_checks++; if (count59 !== bcd(i)) begin n_fail++; $display("FAIL m59_count step=%0d got=%h exp=%h", i, count59, bcd(i)); end
      end
      n_checks++; if (tc59 !== 1'b1) begin n_fail++; $display("FAIL m59_tc got=%b exp=1", tc59); end
      do_step(1'b1);
      n_checks++; if (count59 !== 8'h00 || ovf59 !== 1'b1) begin n_fail++; $display("FAIL m59_wrap got=%h/%b exp=00/1", count59, ovf59); end
      do_step(1'b0);
      n_checks++; if (count59 !== 8'h59 || ovf59 !== 1'b1) begin n_fail++; $display("FAIL m59_down_wrap got=%h/%b exp=59/1", count59, ovf59); end
      do_load(8'h60);
      n_checks++; if (count59 !== 8'h59 || err59 !== 1'b1) begin n_fail++; $display("FAIL m59_load_over got=%h/%b exp=59/1", count59, err59); end
      n_checks++; if (count !== 8'h60 || err !== 1'b0) begin n_fail++; $display("FAIL m99_load_60 got=%h/%b exp=60/0", count, err); end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
      load_val = 8'h00; mode = 2'b00;
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_stop();
      test_reload();
      test_load();
      test_back_to_back();
      test_async_reset();
      test_max59();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
